// File: rtl/branch_resolver_if.sv
// Bundle between the IF/EX datapath, the branch resolver and the predictor update port.
// slave is the resolver side; master is whoever drives fetch/EX info and consumes redirects/updates.
interface branch_resolver_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            ex_is_branch;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_prev_taken;
  logic [XLEN-1:0] upd_target;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispred;

  modport master (
    output stall, if_valid, if_pc, if_pred_taken, if_pred_target,
    output ex_is_branch, ex_taken, ex_target,
    input  flush, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_prev_taken, upd_target,
    input  stat_branches, stat_mispred
  );

  modport slave (
    input  stall, if_valid, if_pc, if_pred_taken, if_pred_target,
    input  ex_is_branch, ex_taken, ex_target,
    output flush, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_prev_taken, upd_target,
    output stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_resolver.sv
// Carries IF-stage predictions down to EX, checks them against the real outcome, flushes/redirects
// and feeds the predictor update bus. Define BR_STATS_EN to get saturating branch/mispredict counters.
module branch_resolver #(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } stage_t;

  // stg[0] is ID, stg[PIPE_DEPTH-1] is EX
  stage_t          stg [PIPE_DEPTH];
  stage_t          ex;
  logic            resolve;
  logic            dir_wrong;
  logic            tgt_wrong;
  logic            alias_hit;
  logic            flush_int;
  logic            upd_fire;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_int;

  assign ex = stg[PIPE_DEPTH-1];

  always_comb begin
    resolve   = ex.valid & ~bus.stall;
    dir_wrong = bus.ex_is_branch & (ex.pred_taken != bus.ex_taken);
    tgt_wrong = bus.ex_is_branch & ex.pred_taken & bus.ex_taken & (ex.pred_target != bus.ex_target);
    alias_hit = ~bus.ex_is_branch & ex.pred_taken;
    pc_plus4  = ex.pc + XLEN'(4);
    flush_int = resolve & (dir_wrong | tgt_wrong | alias_hit);
    upd_fire  = resolve & bus.ex_is_branch;
    redirect_int = '0;
    if (flush_int) begin
      if (dir_wrong)
        redirect_int = bus.ex_taken ? bus.ex_target : pc_plus4;
      else if (tgt_wrong)
        redirect_int = bus.ex_target;
      else
        redirect_int = pc_plus4;
    end
  end

  assign bus.flush       = flush_int;
  assign bus.redirect_pc = redirect_int;

  // A flush kills everything younger than EX, including this cycle's IF capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) stg[i] <= '0;
      bus.upd_valid      <= 1'b0;
      bus.upd_pc         <= '0;
      bus.upd_taken      <= 1'b0;
      bus.upd_prev_taken <= 1'b0;
      bus.upd_target     <= '0;
    end else begin
      bus.upd_valid <= upd_fire;
      if (upd_fire) begin
        bus.upd_pc         <= ex.pc;
        bus.upd_taken      <= bus.ex_taken;
        bus.upd_prev_taken <= ex.pred_taken;
        bus.upd_target     <= bus.ex_target;
      end
      if (!bus.stall) begin
        stg[0] <= '{valid:       bus.if_valid & ~flush_int,
                    pc:          bus.if_pc,
                    pred_taken:  bus.if_pred_taken,
                    pred_target: bus.if_pred_target};
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          stg[i]       <= stg[i-1];
          stg[i].valid <= stg[i-1].valid & ~flush_int;
        end
      end
    end
  end

`ifdef BR_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (upd_fire) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (flush_int && mispred_q != 32'hFFFF_FFFF) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign bus.stat_branches = branches_q;
  assign bus.stat_mispred  = mispred_q;
`else
  assign bus.stat_branches = '0;
  assign bus.stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized + directed bench for branch_resolver, checked against an in-flight instruction queue model.
module tb_branch_resolver;
  localparam int XLEN = 32;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if #(.XLEN(XLEN)) bus ();

  branch_resolver #(.XLEN(XLEN), .PIPE_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // inflight[0] is the instruction sitting in EX, the back of the queue is the youngest (ID)
  rec_t        inflight[$];
  logic        exp_uv, exp_ut, exp_upt;
  logic [31:0] exp_upc, exp_utgt;
  int unsigned m_br, m_mis;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    rec_t z;
    z = '{1'b0, 32'h0, 1'b0, 32'h0};
    inflight = {};
    inflight.push_back(z);
    inflight.push_back(z);
    exp_uv = 0; exp_ut = 0; exp_upt = 0; exp_upc = 0; exp_utgt = 0;
    m_br = 0; m_mis = 0;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic iv, input logic [31:0] ipc,
                               input logic ipt, input logic [31:0] iptg,
                               input logic br, input logic tk, input logic [31:0] tg);
    rec_t        ex, nw;
    logic        exp_flush;
    logic [31:0] exp_redir;
    rst = r;
    bus.stall = s;
    bus.if_valid = iv;
    bus.if_pc = ipc;
    bus.if_pred_taken = ipt;
    bus.if_pred_target = iptg;
    bus.ex_is_branch = br;
    bus.ex_taken = tk;
    bus.ex_target = tg;
    #2;
    ex = inflight[0];
    exp_flush = 1'b0;
    exp_redir = 32'h0;
    if (ex.valid && !s) begin
      if (br && ex.pt != tk) begin
        exp_flush = 1'b1;
        exp_redir = tk ? tg : ex.pc + 32'd4;
      end else if (br && ex.pt && tk && ex.ptgt != tg) begin
        exp_flush = 1'b1;
        exp_redir = tg;
      end else if (!br && ex.pt) begin
        exp_flush = 1'b1;
        exp_redir = ex.pc + 32'd4;
      end
    end
    checkOutput("flush", {31'b0, bus.flush}, {31'b0, exp_flush});
    checkOutput("redirect_pc", bus.redirect_pc, exp_redir);

    @(posedge clk);
    #1;
    if (r) begin
      modelReset();
    end else if (s) begin
      exp_uv = 1'b0;
    end else begin
      exp_uv = ex.valid && br;
      if (exp_uv) begin
        exp_upc = ex.pc; exp_ut = tk; exp_upt = ex.pt; exp_utgt = tg;
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (exp_flush && m_mis != 32'hFFFF_FFFF) m_mis++;
      end
      void'(inflight.pop_front());
      nw = '{iv, ipc, ipt, iptg};
      inflight.push_back(nw);
      if (exp_flush) foreach (inflight[i]) inflight[i].valid = 1'b0;
    end
    checkOutput("upd_valid", {31'b0, bus.upd_valid}, {31'b0, exp_uv});
    checkOutput("upd_pc", bus.upd_pc, exp_upc);
    checkOutput("upd_taken", {31'b0, bus.upd_taken}, {31'b0, exp_ut});
    checkOutput("upd_prev_taken", {31'b0, bus.upd_prev_taken}, {31'b0, exp_upt});
    checkOutput("upd_target", bus.upd_target, exp_utgt);
`ifdef BR_STATS_EN
    checkOutput("stat_branches", bus.stat_branches, m_br);
    checkOutput("stat_mispred", bus.stat_mispred, m_mis);
`else
    checkOutput("stat_branches", bus.stat_branches, 32'h0);
    checkOutput("stat_mispred", bus.stat_mispred, 32'h0);
`endif
  endtask

  // Capture in IF, one bubble, then resolve in EX
  task automatic runBranch(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                           input logic br, input logic tk, input logic [31:0] tg);
    applyStimulus(0, 0, 1, pc, pt, ptgt, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, br, tk, tg);
  endtask

  function automatic logic [31:0] pickAddr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0: a = 32'h100;
      1: a = 32'h200;
      2: a = 32'h340;
      3: a = 32'hFFFF_FFFC;
      4: a = 32'h24;
      default: a = $urandom() & 32'hFFFF_FFFC;
    endcase
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_pred_taken = 0; bus.if_pred_target = 0;
    bus.ex_is_branch = 0; bus.ex_taken = 0; bus.ex_target = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

    $display("[TB] correct taken prediction");
    runBranch(32'h100, 1, 32'h200, 1, 1, 32'h200);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

    $display("[TB] direction mispredict, then killed younger stages");
    runBranch(32'h40, 0, 32'h0, 1, 1, 32'h80);
    applyStimulus(0, 0, 1, 32'h44, 1, 32'h99, 1, 1, 32'h123);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0);

    $display("[TB] target mispredict and PC wrap");
    runBranch(32'h500, 1, 32'h300, 1, 1, 32'h340);
    runBranch(32'hFFFF_FFFC, 1, 32'h10, 1, 0, 32'h10);

    $display("[TB] stalled mispredict");
    applyStimulus(0, 0, 1, 32'h60, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    repeat (3) applyStimulus(0, 1, 1, 32'h64, 0, 32'h0, 1, 1, 32'h90);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h90);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

    $display("[TB] alias: non-branch predicted taken");
    runBranch(32'h20, 1, 32'h50, 0, 0, 32'h0);

    $display("[TB] five branches, two mispredicts, then mid-stream reset");
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    runBranch(32'h100, 1, 32'h200, 1, 1, 32'h200);
    runBranch(32'h104, 0, 32'h0, 1, 1, 32'h180);
    runBranch(32'h108, 0, 32'h0, 1, 0, 32'h0);
    runBranch(32'h10C, 1, 32'h300, 1, 1, 32'h340);
    runBranch(32'h110, 1, 32'h400, 1, 1, 32'h400);
    applyStimulus(0, 0, 1, 32'h200, 1, 32'h10, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 32'h204, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 1, 1, 32'h208, 1, 32'h20, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0, pickAddr(), 1'($urandom_range(0, 1)), pickAddr(),
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pickAddr());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- EX-stage counterpart of the fetch-side branch predictor.
- Carries each fetched instruction's prediction (taken flag and target) through IF→ID→EX and compares it with the actual outcome resolved in EX.
- On a mismatch: flushes younger stages and redirects the PC.
- Drives a registered update bus back to the predictor table.

Parameters:
- XLEN, 32, PC/target width
- PIPE_DEPTH, 2, register stages between IF capture and EX compare (IF→ID, ID→EX); fixed at 2 in this design

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- stall  input  1  memory stall; freezes all pipeline regs, suppresses resolution
- if_valid  input  1  IF stage holds a real instruction
- if_pc  input  XLEN  PC of IF instruction
- if_pred_taken  input  1  predictor said taken
- if_pred_target  input  XLEN  predicted target (don't-care if not taken)
- ex_is_branch  input  1  EX instruction is a conditional branch or jump
- ex_taken  input  1  actual direction in EX
- ex_target  input  XLEN  actual target in EX
- flush  output  1  kill IF/ID, redirect fetch (combinational from EX regs)
- redirect_pc  output  XLEN  correct next PC when flush=1, else 0
- upd_valid  output  1  one-cycle pulse: predictor update
- upd_pc  output  XLEN  PC of resolved branch
- upd_taken  output  1  actual direction
- upd_prev_taken  output  1  predicted direction carried from IF
- upd_target  output  XLEN  actual target
- stat_branches  output  32  resolved branch count (BR_STATS_EN)
- stat_mispred  output  32  mispredict count (BR_STATS_EN)

Behaviour:
- Stage regs ID and EX each hold {valid, pc, pred_taken, pred_target}. Reset clears both to all-zero.
- Advance rules, when stall=0:
  - EX←ID, ID←{if_valid, if_pc, if_pred_taken, if_pred_target}.
  - If flush=1 this cycle, EX.valid and ID.valid load 0 (wrong-path kill); other fields are don't-care.
- When stall=1: all stage regs hold; flush=0; redirect_pc=0; no upd_valid is generated.
- Resolution, evaluated only when EX.valid & !stall:
  - Direction wrong when ex_is_branch & (EX.pred_taken != ex_taken). Redirect = ex_taken ? ex_target : EX.pc+4.
  - Target wrong when ex_is_branch & EX.pred_taken & ex_taken & (EX.pred_target != ex_target). Redirect = ex_target.
  - Alias: !ex_is_branch & EX.pred_taken, i.e. a non-branch was predicted taken. Redirect = EX.pc+4.
  - flush = any of the three conditions. PC+4 wraps modulo 2^XLEN.
- Update bus:
  - When EX.valid & ex_is_branch & !stall, the next edge registers upd_valid=1 with upd_pc=EX.pc, upd_taken=ex_taken, upd_prev_taken=EX.pred_taken, upd_target=ex_target.
  - Otherwise upd_valid=0 and the other upd_* fields hold their last value.
  - Latency is 1 cycle after resolution. upd_valid is never held across stalls.
  - Alias cases produce no update.
- Reset values: all upd_*, flush, redirect_pc, and stats are 0.
- Reset asserted mid-operation wins over stall and flush on the same edge.
- Simultaneous flush and an if_valid capture: the capture is discarded (ID.valid=0).

Optional Feature:
- BR_STATS_EN defined:
  - stat_branches increments on every cycle that also produces upd_valid.
  - stat_mispred increments when that same resolution has flush=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- BR_STATS_EN undefined: both ports are constant 0 and no counter flops are instantiated.

Test Plan:
- Correct taken prediction: IF pc=0x100, pred_taken=1, target=0x200; two cycles later ex_is_branch=1, taken=1, target=0x200 → flush=0; next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, upd_prev_taken=1.
- Direction mispredict: pc=0x40 predicted not-taken; EX taken=1, target=0x80 → flush=1, redirect_pc=0x80; the following cycle EX.valid=0 and ID.valid=0, so no second flush.
- Target mispredict: predicted taken to 0x300, actual 0x340 → flush=1, redirect_pc=0x340, upd_target=0x340. Not-taken misprediction at pc=0xFFFF_FFFC → redirect_pc=0x0 (wrap).
- Stall: mispredicting branch sits in EX with stall=1 for 3 cycles → flush=0 and upd_valid=0 throughout; on the first cycle with stall=0, flush=1 and one upd_valid pulse follows.
- Alias: non-branch with pred_taken=1 at pc=0x20 → flush=1, redirect_pc=0x24, upd_valid stays 0.
- BR_STATS_EN: 5 branches including 2 mispredicts → stat_branches=5, stat_mispred=2; rst asserted mid-stream clears both counters plus ID/EX valid on the next edge.
